reel_spinner: RTL and testbench
===============================

Name: reel_spinner

Overview:
- Producer of the four reel digits that the bank block consumes: generates reel1..reel4 plus a one-cycle result strobe per play.
- Accepts a debounced spin button, animates all reels, stops them one at a time, then presents the final digits and a jackpot flag.
- Sits between the button/switch inputs and the bank; reel outputs also drive the seven-segment display mux.

Parameters:
- SPIN_TICKS, 4, clk cycles per animation step (>=1)
- STOP_GAP, 8, animation steps between successive reel stops (>=1)
- DIGIT_MAX, 9, highest reel digit; reels range 0..DIGIT_MAX (<=15)
- SEED, 16'hACE1, LFSR reset value; must be non-zero

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- spin  in  1  debounced spin button, level; rising edge requests a play
- bet_nonzero  in  1  high when any bet switch is on
- balance_zero  in  1  high when bank balance is 0
- reel1..reel4  out  4 each  reel digits, registered
- spinning  out  1  high while in SPIN
- result_valid  out  1  one-cycle pulse; reels hold final result
- jackpot  out  1  valid with result_valid: all four reels equal

Behaviour:
- Reset: state IDLE; reels 0; spinning, result_valid, jackpot 0; LFSR = SEED; counters 0; spin edge register 0.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Advances every clock in every state, including IDLE, so button timing adds entropy.
- Edge detect: spin_q is registered. start = spin & ~spin_q & bet_nonzero & ~balance_zero.
- IDLE -> SPIN on start.
  - On entry: tick_cnt = 0, step_cnt = 0, stop_idx = 0.
  - Spin presses outside IDLE are ignored; no queuing.
- SPIN:
  - tick_cnt counts 0..SPIN_TICKS-1; step strobe when tick_cnt = SPIN_TICKS-1.
  - On each step strobe, every reel with index >= stop_idx increments, wrapping DIGIT_MAX -> 0.
  - step_cnt counts steps 0..STOP_GAP-1. On a step strobe with step_cnt = STOP_GAP-1, reel[stop_idx] stops.
  - A stopping reel latches LFSR nibble[stop_idx]. Reduction: n > DIGIT_MAX ? n-(DIGIT_MAX+1) : n, clamped to DIGIT_MAX. Small bias is accepted.
  - The stop replaces the increment on that strobe. stop_idx then increments.
  - After the fourth stop (stop_idx becomes 4) -> DONE.
  - SPIN lasts exactly 4*STOP_GAP*SPIN_TICKS cycles; spinning is high throughout.
- DONE (one cycle): result_valid = 1; jackpot = (reel1==reel2==reel3==reel4); spinning = 0. Next state IDLE.
- jackpot is 0 whenever result_valid is 0. Reels hold their values in IDLE until the next play.
- Inputs during SPIN: bet_nonzero and balance_zero changes are ignored once SPIN has started.
- Reset mid-spin: immediate IDLE, reels 0, no result_valid pulse.
- Reset and spin edge in the same cycle: reset wins.

Optional Feature:
- Macro FORCE_JACKPOT_EN.
- When defined: adds input force_jackpot (1 bit). If force_jackpot = 1 at the reel1 stop, reels 2..4 latch reel1's stopped value at their own stops, so jackpot = 1. Used for demo and bank-payout testing.
- When undefined: the port is absent and behaviour is as above.

Decomposition:
- Package slot_pkg:
  - NUM_REELS = 4, DIGIT_W = 4, LFSR_W = 16, LFSR_TAPS = 16'hB400
  - state enum {IDLE, SPIN, DONE}
  - function reduce_digit(nibble, max)
- Sub-module lfsr16: clk, rst, seed param, q[15:0]. It is free-running and reusable by other random-source users.

Test Plan:
- Reset: assert rst for 2 cycles -> all reels 0, spinning 0, result_valid 0; LFSR equals SEED on the first cycle after release.
- Normal play (SPIN_TICKS=2, STOP_GAP=3): rising spin with bet_nonzero=1, balance_zero=0 -> spinning high for exactly 24 cycles, then result_valid pulses one cycle; reel1..4 each <= 9 and stable afterwards.
- Blocked start: spin edge with balance_zero=1, or with bet_nonzero=0 -> stays IDLE, spinning never rises, no result_valid.
- Ignored presses and reset mid-spin:
  - Extra spin edges at cycles 5 and 10 of a play -> exactly one result_valid, at cycle 24.
  - rst at cycle 12 -> reels 0, no pulse.
- Range and jackpot: 2000 back-to-back plays -> every reel <= DIGIT_MAX at every cycle; jackpot equals the four-way reel equality on every pulse; at least one value wrap 9 -> 0 observed during animation.
- FORCE_JACKPOT_EN build: force_jackpot=1 through a play -> reel1==reel2==reel3==reel4 and jackpot=1 with result_valid.

Source files
------------

// File: rtl/slot_pkg.sv
// Shared types and constants for the slot machine reel datapath.
package slot_pkg;

  localparam int NUM_REELS = 4;
  localparam int DIGIT_W   = 4;
  localparam int LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SPIN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Fold a raw nibble into 0..max; the small bias is acceptable.
  function automatic logic [DIGIT_W-1:0] reduce_digit(
    input logic [DIGIT_W-1:0] nibble,
    input logic [DIGIT_W-1:0] max
  );
    logic [DIGIT_W:0] r;
    r = {1'b0, nibble};
    if (nibble > max)
      r = {1'b0, nibble} - ({1'b0, max} + 5'd1);
    if (r > {1'b0, max})
      r = {1'b0, max};
    return r[DIGIT_W-1:0];
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1.
module lfsr16
  import slot_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0])
      lfsr_d = lfsr_d ^ LFSR_TAPS;
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/reel_spinner.sv
// Four-reel spinner: animate, stop reels one by one, flag a jackpot.
// Optional FORCE_JACKPOT_EN adds a force_jackpot input for demo payouts.
module reel_spinner
  import slot_pkg::*;
#(
  parameter int          SPIN_TICKS = 4,
  parameter int          STOP_GAP   = 8,
  parameter int          DIGIT_MAX  = 9,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spin,
  input  logic       bet_nonzero,
  input  logic       balance_zero,
`ifdef FORCE_JACKPOT_EN
  input  logic       force_jackpot,
`endif
  output logic [3:0] reel1,
  output logic [3:0] reel2,
  output logic [3:0] reel3,
  output logic [3:0] reel4,
  output logic       spinning,
  output logic       result_valid,
  output logic       jackpot
);

  localparam int TW = (SPIN_TICKS > 1) ? $clog2(SPIN_TICKS) : 1;
  localparam int SW = (STOP_GAP > 1) ? $clog2(STOP_GAP) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SPIN_TICKS - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STOP_GAP - 1);
  localparam logic [DIGIT_W-1:0] DMAX = DIGIT_W'(DIGIT_MAX);

  state_t state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [SW-1:0] step_q, step_d;
  logic [2:0]    stop_q, stop_d;
  logic          spin_q;
  logic [NUM_REELS-1:0][DIGIT_W-1:0] reel_q, reel_d;
  logic [15:0]   rnd;
  logic          start;
  logic          step_stb;
  logic          gap_end;
  logic [DIGIT_W-1:0] stop_val;

`ifdef FORCE_JACKPOT_EN
  logic force_q, force_d;
`endif

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (rnd)
  );

  assign start    = spin & ~spin_q & bet_nonzero & ~balance_zero;
  assign step_stb = (tick_q == TICK_LAST);
  assign gap_end  = (step_q == STEP_LAST);

  always_comb begin
    stop_val = reduce_digit(rnd[{stop_q[1:0], 2'b00} +: 4], DMAX);
`ifdef FORCE_JACKPOT_EN
    // Forced plays copy reel1's landed digit onto later reels.
    if (force_q && stop_q != 3'd0)
      stop_val = reel_q[0];
`endif
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    step_d  = step_q;
    stop_d  = stop_q;
    reel_d  = reel_q;
`ifdef FORCE_JACKPOT_EN
    force_d = force_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SPIN;
          tick_d  = '0;
          step_d  = '0;
          stop_d  = '0;
`ifdef FORCE_JACKPOT_EN
          force_d = 1'b0;
`endif
        end
      end
      SPIN: begin
        tick_d = step_stb ? '0 : tick_q + 1'b1;
        if (step_stb) begin
          step_d = gap_end ? '0 : step_q + 1'b1;
          for (int i = 0; i < NUM_REELS; i++) begin
            if (i >= int'(stop_q))
              reel_d[i] = (reel_q[i] == DMAX) ? '0 : reel_q[i] + 1'b1;
          end
          if (gap_end) begin
            reel_d[stop_q[1:0]] = stop_val;
            stop_d = stop_q + 3'd1;
            if (stop_q == 3'd3)
              state_d = DONE;
`ifdef FORCE_JACKPOT_EN
            if (stop_q == 3'd0)
              force_d = force_jackpot;
`endif
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      step_q  <= '0;
      stop_q  <= '0;
      spin_q  <= 1'b0;
      reel_q  <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      step_q  <= step_d;
      stop_q  <= stop_d;
      spin_q  <= spin;
      reel_q  <= reel_d;
    end
  end

`ifdef FORCE_JACKPOT_EN
  always_ff @(posedge clk) begin
    if (rst) force_q <= 1'b0;
    else     force_q <= force_d;
  end
`endif

  assign reel1        = reel_q[0];
  assign reel2        = reel_q[1];
  assign reel3        = reel_q[2];
  assign reel4        = reel_q[3];
  assign spinning     = (state_q == SPIN);
  assign result_valid = (state_q == DONE);
  assign jackpot      = result_valid
                        & (reel_q[0] == reel_q[1])
                        & (reel_q[1] == reel_q[2])
                        & (reel_q[2] == reel_q[3]);

endmodule

// File: tb/tb_reel_spinner.sv
// Directed bench for reel_spinner with SPIN_TICKS=2, STOP_GAP=3.
module tb_reel_spinner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spin = 1'b0;
  logic bet_nonzero = 1'b1;
  logic balance_zero = 1'b0;
`ifdef FORCE_JACKPOT_EN
  logic force_jackpot = 1'b0;
`endif
  logic [3:0] reel1, reel2, reel3, reel4;
  logic spinning, result_valid, jackpot;

  int checks = 0;
  int errors = 0;
  int range_err = 0;
  bit wrap_seen = 1'b0;
  logic [3:0] prev_r1 = 4'd0;
  logic [15:0] ref_lfsr;

  always #5 clk = ~clk;

  reel_spinner #(
    .SPIN_TICKS (2),
    .STOP_GAP   (3),
    .DIGIT_MAX  (9),
    .SEED       (16'hACE1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .spin         (spin),
    .bet_nonzero  (bet_nonzero),
    .balance_zero (balance_zero),
`ifdef FORCE_JACKPOT_EN
    .force_jackpot(force_jackpot),
`endif
    .reel1        (reel1),
    .reel2        (reel2),
    .reel3        (reel3),
    .reel4        (reel4),
    .spinning     (spinning),
    .result_valid (result_valid),
    .jackpot      (jackpot)
  );

  // Reference LFSR: right-shift Galois, taps x^16+x^14+x^13+x^11+1.
  always @(posedge clk) begin
    if (rst) ref_lfsr <= 16'hACE1;
    else ref_lfsr <= {1'b0, ref_lfsr[15:1]} ^ (ref_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  always @(negedge clk) begin
    if (reel1 > 4'd9 || reel2 > 4'd9 || reel3 > 4'd9 || reel4 > 4'd9)
      range_err++;
    if (spinning && prev_r1 == 4'd9 && reel1 == 4'd0)
      wrap_seen = 1'b1;
    prev_r1 = reel1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] fold(input logic [3:0] n);
    return (n > 4'd9) ? n - 4'd10 : n;
  endfunction

  // One full play; caller is 1 time unit after an edge with state IDLE.
  task automatic play(input bit extra, input bit toggle, input bit fj);
    logic [3:0] e [4];
    logic [3:0] n;
    bit bad;
    bit jp;
    int k;
    bad = 1'b0;
    bet_nonzero = 1'b1;
    balance_zero = 1'b0;
`ifdef FORCE_JACKPOT_EN
    force_jackpot = fj;
`endif
    spin = 1'b1;
    tick();
    spin = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (spinning !== 1'b1 || result_valid !== 1'b0 || jackpot !== 1'b0)
        bad = 1'b1;
      if (extra && (i == 5 || i == 10)) spin = 1'b1;
      if (extra && (i == 6 || i == 11)) spin = 1'b0;
      if (toggle && i == 3) begin
        bet_nonzero = 1'b0;
        balance_zero = 1'b1;
      end
      if (i % 6 == 5) begin
        k = i / 6;
        n = ref_lfsr[4*k +: 4];
        e[k] = fold(n);
        if (fj && k > 0) e[k] = e[0];
      end
      tick();
    end
    check("spin_window", {31'd0, bad}, 32'd0);
    check("rv_pulse", {31'd0, result_valid}, 32'd1);
    check("spin_low_done", {31'd0, spinning}, 32'd0);
    check("reels_final", {16'd0, reel1, reel2, reel3, reel4},
          {16'd0, e[0], e[1], e[2], e[3]});
    jp = (e[0] == e[1]) && (e[1] == e[2]) && (e[2] == e[3]);
    check("jackpot", {31'd0, jackpot}, {31'd0, jp});
    bet_nonzero = 1'b1;
    balance_zero = 1'b0;
    tick();
    check("rv_one_cycle", {31'd0, result_valid}, 32'd0);
    check("jackpot_idle", {31'd0, jackpot}, 32'd0);
    check("reels_hold", {16'd0, reel1, reel2, reel3, reel4},
          {16'd0, e[0], e[1], e[2], e[3]});
  endtask

  typedef struct {
    logic bet;
    logic bal;
    logic exp_start;
  } vec_t;

  vec_t vecs [5];

  initial begin
    bit bad;
    vecs[0] = '{bet: 1'b1, bal: 1'b0, exp_start: 1'b1};
    vecs[1] = '{bet: 1'b1, bal: 1'b1, exp_start: 1'b0};
    vecs[2] = '{bet: 1'b0, bal: 1'b0, exp_start: 1'b0};
    vecs[3] = '{bet: 1'b0, bal: 1'b1, exp_start: 1'b0};
    vecs[4] = '{bet: 1'b1, bal: 1'b0, exp_start: 1'b1};

    // Reset held for two edges.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_reels", {16'd0, reel1, reel2, reel3, reel4}, 32'd0);
    check("rst_spinning", {31'd0, spinning}, 32'd0);
    check("rst_rv", {31'd0, result_valid}, 32'd0);
    check("rst_jackpot", {31'd0, jackpot}, 32'd0);
    check("rst_lfsr", {16'd0, dut.u_lfsr.q}, 32'h0000ACE1);
    check("ref_lfsr_seed", {16'd0, dut.u_lfsr.q}, {16'd0, ref_lfsr});
    tick();

    // Start gating vectors.
    foreach (vecs[v]) begin
      if (vecs[v].exp_start) begin
        play(1'b0, 1'b0, 1'b0);
      end else begin
        bad = 1'b0;
        bet_nonzero = vecs[v].bet;
        balance_zero = vecs[v].bal;
        spin = 1'b1;
        for (int i = 0; i < 8; i++) begin
          tick();
          if (spinning !== 1'b0 || result_valid !== 1'b0) bad = 1'b1;
        end
        spin = 1'b0;
        tick();
        check("blocked_start", {31'd0, bad}, 32'd0);
      end
    end
    bet_nonzero = 1'b1;
    balance_zero = 1'b0;

    // Extra presses and input changes mid-spin are ignored.
    play(1'b1, 1'b0, 1'b0);
    play(1'b0, 1'b1, 1'b0);

    // Reset at cycle 12 of a play.
    spin = 1'b1;
    tick();
    spin = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("pre_rst_spinning", {31'd0, spinning}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_reels", {16'd0, reel1, reel2, reel3, reel4}, 32'd0);
    check("midrst_spinning", {31'd0, spinning}, 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (result_valid !== 1'b0 || spinning !== 1'b0) bad = 1'b1;
      tick();
    end
    check("midrst_no_pulse", {31'd0, bad}, 32'd0);
    check("midrst_reels_hold", {16'd0, reel1, reel2, reel3, reel4}, 32'd0);

    // Reset and spin edge together: reset wins.
    rst = 1'b1;
    spin = 1'b1;
    tick();
    rst = 1'b0;
    spin = 1'b0;
    tick();
    check("rst_beats_spin", {31'd0, spinning}, 32'd0);

`ifdef FORCE_JACKPOT_EN
    play(1'b0, 1'b0, 1'b1);
    check("forced_jackpot_hold", {31'd0, reel1 == reel2 && reel2 == reel3 && reel3 == reel4}, 32'd1);
`endif

    // Back-to-back plays.
    for (int p = 0; p < 2000; p++) play(1'b0, 1'b0, 1'b0);

    check("reel_range", range_err, 32'd0);
    check("wrap_seen", {31'd0, wrap_seen}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
